fft_host_ctrl: RTL and testbench
================================

// Module: fft_host_ctrl
// PURPOSE
//  Host-side frame controller for the FFT datapath.
//  - Host writes one frame of input samples into a buffer through a simple write port.
//  - On start, streams the frame into an FFT core over a valid/ready link.
//  - Collects N results into an output buffer, in natural or bit-reversed order.
//  - Host reads results with 1-cycle latency.
//  - Sits between the VIO/host register port and the FFT core; generalised in points and widths.
// PARAMETERS
//  N_POINTS  32                 frame length; power of two, >=4
//  ADDR_W    $clog2(N_POINTS)   host address width
//  IN_W      16                 input sample width
//  OUT_W     32                 result width (packed re/im)
//  BITREV    0                  1: result beat k stored at bitrev(k); 0: stored at k
// PORTS
//  clk            in   1       system clock
//  rst_n          in   1       asynchronous active-low reset
//  m_addr         in   ADDR_W  input buffer write address
//  m_data         in   IN_W    input buffer write data
//  m_we           in   1       input buffer write enable
//  start          in   1       start frame (sampled high)
//  s_addr         in   ADDR_W  output buffer read address
//  s_re           in   1       output buffer read enable
//  s_data         out  OUT_W   read data, valid when s_valid=1
//  s_valid        out  1       1-cycle pulse, read data returned
//  busy           out  1       frame in progress
//  done           out  1       frame complete; level, held until next start
//  wr_err         out  1       sticky: host write attempted while busy
//  frame_err      out  1       sticky: core_out_last not exactly on beat N-1
//  core_in_data   out  IN_W    sample to core
//  core_in_valid  out  1       sample valid
//  core_in_last   out  1       marks sample N-1
//  core_in_ready  in   1       core accepts sample
//  core_out_data  in   OUT_W   result from core
//  core_out_valid in   1       result valid
//  core_out_last  in   1       core marks final result
//  core_out_ready out  1       controller accepts result
// BEHAVIOUR
//  Reset (async, rst_n=0):
//   - state=IDLE; all outputs 0; counters 0.
//   - Buffer contents are not reset.
//  States: IDLE -> SEND -> COLLECT -> DONE -> (start) SEND.
//  start acceptance:
//   - Accepted only in IDLE or DONE; ignored while busy.
//   - On accept: busy=1, done=0, wr_err=0, frame_err=0, rd_ptr=0.
//  Host writes:
//   - m_we in IDLE/DONE writes in_buf[m_addr].
//   - m_we in SEND/COLLECT is dropped and sets wr_err.
//   - start and m_we in the same cycle: write lands, then frame starts.
//  SEND:
//   - Sync-read input buffer; core_in_valid first rises 2 cycles after start is sampled.
//   - core_in_data/last registered; held stable while valid && !ready.
//   - Transfer on valid&&ready; rd_ptr++; core_in_last=1 on index N-1.
//   - After the last transfer: valid=0 next cycle; state=COLLECT.
//  COLLECT:
//   - core_out_ready=1; ready=0 in all other states.
//   - Each valid&&ready beat k (0..N-1) writes out_buf[BITREV ? bitrev(k) : k].
//   - Exactly N beats counted; core_out_last is only checked: sets frame_err if high on k!=N-1 or low on k=N-1.
//   - After beat N-1 -> DONE: busy=0, done=1.
//  Host reads:
//   - s_re in IDLE/DONE: s_data=out_buf[s_addr] and s_valid=1 on the next cycle.
//   - s_data holds its value otherwise.
//   - s_re while busy is ignored; s_valid stays 0.
//  Reset mid-frame: abandons the frame immediately; the next start runs a full N-sample frame.
//  Widths: counters ADDR_W+1 bits; no arithmetic on data (pass-through).
// STRUCTURE
//  Package fft_io_pkg:
//   - state enum (IDLE, SEND, COLLECT, DONE).
//   - function bitrev(idx, ADDR_W).
//   - default N_POINTS/IN_W/OUT_W constants.
//  Sub-module fft_sdp_ram (WIDTH, DEPTH):
//   - Simple dual-port, 1 write port, 1 sync read port, 1-cycle read latency.
//   - Instantiated twice: in_buf (IN_W) and out_buf (OUT_W).
//  Control FSM, counters and the core_in output register stay in this module.
// TESTING
//  1. Load in_buf[k]=k; start; core model always ready, returns 32'hA000_0000+k on beat k; BITREV=0.
//     -> done=1; s_re with s_addr=5 gives s_data=32'hA000_0005, s_valid=1 the next cycle.
//  2. BITREV=1, same stimulus as 1.
//     -> read s_addr=16 gives 32'hA000_0001; read s_addr=31 gives 32'hA000_001F.
//  3. core_in_ready toggles 1,0,1,0...
//     -> exactly 32 transfers carrying 0..31 in order; core_in_last only with data 31; data stable during stalls.
//  4. m_we to addr 3 with data 16'hDEAD during SEND.
//     -> wr_err=1; next frame still sends 3 at index 3; wr_err clears on the next accepted start.
//  5. Core model asserts core_out_last on beat 10.
//     -> frame_err=1; done still rises only after beat 31.
//  6. rst_n low for 1 cycle mid-COLLECT.
//     -> busy=0, done=0, core_in_valid=0, core_out_ready=0 at once; a new start completes a full frame.

Source files
------------

// File: rtl/fft_io_pkg.sv
// rtl/fft_io_pkg.sv - shared types, default geometry and index helper for the FFT host controller
// Purpose: frame-controller state encoding, default frame length/widths,
//          and the bit-reverse helper used to place results in bit-reversed order.
// Ports:   none (package).
package fft_io_pkg;

  localparam int DEF_N_POINTS = 32;
  localparam int DEF_IN_W     = 16;
  localparam int DEF_OUT_W    = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SEND    = 2'd1,
    COLLECT = 2'd2,
    DONE    = 2'd3
  } fft_state_t;

  // Reverse the low 'width' bits of idx; bits at and above 'width' come back as 0.
  function automatic logic [31:0] bitrev(input logic [31:0] idx, input int width);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < width; i++) begin
      r[i] = idx[width-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_sdp_ram.sv
// rtl/fft_sdp_ram.sv - simple dual-port buffer, one write port, one synchronous read port
// Purpose: frame buffer with 1-cycle read latency; read data holds when re=0.
//          Array contents are not reset; only the read register is.
// Ports:   clk, rst_n       clock, async active-low reset (read register only)
//          we/waddr/wdata   write port
//          re/raddr         read request
//          rdata            read data, valid the cycle after re
module fft_sdp_ram #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 32,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/fft_host_ctrl.sv
// rtl/fft_host_ctrl.sv - host-side frame controller feeding and draining an FFT core
// Purpose: host loads a frame into in_buf, start streams it to the core over
//          valid/ready, N results are collected into out_buf (natural or
//          bit-reversed order) and read back by the host with 1-cycle latency.
// Ports:   clk, rst_n                       clock, async active-low reset
//          m_addr/m_data/m_we               input buffer write port
//          start                            frame start
//          s_addr/s_re -> s_data/s_valid    output buffer read port
//          busy/done                        frame status
//          wr_err/frame_err                 sticky error flags
//          core_in_*                        sample stream to the core
//          core_out_*                       result stream from the core
module fft_host_ctrl
  import fft_io_pkg::*;
#(
  parameter int N_POINTS = DEF_N_POINTS,
  parameter int ADDR_W   = $clog2(N_POINTS),
  parameter int IN_W     = DEF_IN_W,
  parameter int OUT_W    = DEF_OUT_W,
  parameter bit BITREV   = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] m_addr,
  input  logic [IN_W-1:0]   m_data,
  input  logic              m_we,
  input  logic              start,
  input  logic [ADDR_W-1:0] s_addr,
  input  logic              s_re,
  output logic [OUT_W-1:0]  s_data,
  output logic              s_valid,
  output logic              busy,
  output logic              done,
  output logic              wr_err,
  output logic              frame_err,
  output logic [IN_W-1:0]   core_in_data,
  output logic              core_in_valid,
  output logic              core_in_last,
  input  logic              core_in_ready,
  input  logic [OUT_W-1:0]  core_out_data,
  input  logic              core_out_valid,
  input  logic              core_out_last,
  output logic              core_out_ready
);

  localparam int               CNT_W    = ADDR_W + 1;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_POINTS - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(N_POINTS);

  fft_state_t state, state_nxt;

  logic              idle_like;
  logic              accept;
  logic              xfer;
  logic              beat;
  logic              load;
  logic              q_ok;
  logic              in_we;
  logic              out_re;
  logic [CNT_W-1:0]  rd_ptr;   // samples accepted by the core
  logic [CNT_W-1:0]  ld_ptr;   // samples loaded into the core_in register
  logic [CNT_W-1:0]  wr_ptr;   // result beats collected
  logic [ADDR_W-1:0] in_raddr;
  logic [ADDR_W-1:0] out_waddr;
  logic [IN_W-1:0]   in_q;

  assign idle_like = (state == IDLE) || (state == DONE);
  assign accept    = start && idle_like;
  assign xfer      = core_in_valid && core_in_ready;
  assign beat      = core_out_valid && core_out_ready;
  assign in_we     = m_we && idle_like;
  assign out_re    = s_re && idle_like;

  // in_q always holds in_buf[ld_ptr] once q_ok is set: the read address runs
  // one ahead whenever the output register is reloaded this cycle, which keeps
  // the stream at one sample per cycle with a 2-cycle start-up latency.
  assign load     = (state == SEND) && q_ok && (ld_ptr != CNT_FULL) &&
                    (!core_in_valid || core_in_ready);
  assign in_raddr = ld_ptr[ADDR_W-1:0] + ADDR_W'(load);

  assign out_waddr = BITREV ? ADDR_W'(bitrev(32'(wr_ptr), ADDR_W)) : wr_ptr[ADDR_W-1:0];

  fft_sdp_ram #(
    .WIDTH (IN_W),
    .DEPTH (N_POINTS),
    .AW    (ADDR_W)
  ) in_buf (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (in_we),
    .waddr (m_addr),
    .wdata (m_data),
    .re    (state == SEND),
    .raddr (in_raddr),
    .rdata (in_q)
  );

  fft_sdp_ram #(
    .WIDTH (OUT_W),
    .DEPTH (N_POINTS),
    .AW    (ADDR_W)
  ) out_buf (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (beat),
    .waddr (out_waddr),
    .wdata (core_out_data),
    .re    (out_re),
    .raddr (s_addr),
    .rdata (s_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    busy           = 1'b0;
    done           = 1'b0;
    core_out_ready = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = SEND;
      end
      SEND: begin
        busy = 1'b1;
        if (xfer && (rd_ptr == CNT_LAST)) state_nxt = COLLECT;
      end
      COLLECT: begin
        busy           = 1'b1;
        core_out_ready = 1'b1;
        if (beat && (wr_ptr == CNT_LAST)) state_nxt = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (start) state_nxt = SEND;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr        <= '0;
      ld_ptr        <= '0;
      wr_ptr        <= '0;
      q_ok          <= 1'b0;
      core_in_data  <= '0;
      core_in_valid <= 1'b0;
      core_in_last  <= 1'b0;
      wr_err        <= 1'b0;
      frame_err     <= 1'b0;
      s_valid       <= 1'b0;
    end else begin
      s_valid <= out_re;
      // First SEND cycle only issues the read of sample 0.
      q_ok    <= (state == SEND);
      if (accept) begin
        rd_ptr        <= '0;
        ld_ptr        <= '0;
        wr_ptr        <= '0;
        wr_err        <= 1'b0;
        frame_err     <= 1'b0;
        core_in_valid <= 1'b0;
        core_in_last  <= 1'b0;
      end else begin
        if (m_we && busy) begin
          wr_err <= 1'b1;
        end
        if (load) begin
          core_in_data  <= in_q;
          core_in_valid <= 1'b1;
          core_in_last  <= (ld_ptr == CNT_LAST);
          ld_ptr        <= ld_ptr + CNT_ONE;
        end else if (xfer) begin
          core_in_valid <= 1'b0;
          core_in_last  <= 1'b0;
        end
        if (xfer) begin
          rd_ptr <= rd_ptr + CNT_ONE;
        end
        // The beat count alone ends the frame; core_out_last is only audited.
        if (beat) begin
          wr_ptr <= wr_ptr + CNT_ONE;
          if (core_out_last != (wr_ptr == CNT_LAST)) begin
            frame_err <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_fft_host_ctrl.sv
// tb/tb_fft_host_ctrl.sv - directed self-checking bench for fft_host_ctrl
module tb_fft_host_ctrl;

  localparam int N  = 32;
  localparam int AW = 5;
  localparam int IW = 16;
  localparam int OW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [AW-1:0] m_addr = '0;
  logic [IW-1:0] m_data = '0;
  logic          m_we = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] s_addr = '0;
  logic          s_re = 1'b0;
  logic          core_in_ready = 1'b0;
  logic [OW-1:0] core_out_data = '0;
  logic          core_out_valid = 1'b0;
  logic          core_out_last = 1'b0;

  logic [OW-1:0] o0_s_data, o1_s_data;
  logic          o0_s_valid, o1_s_valid, o0_busy, o1_busy, o0_done, o1_done;
  logic          o0_wr_err, o1_wr_err, o0_frame_err, o1_frame_err;
  logic [IW-1:0] o0_core_in_data, o1_core_in_data;
  logic          o0_core_in_valid, o1_core_in_valid, o0_core_in_last, o1_core_in_last;
  logic          o0_core_out_ready, o1_core_out_ready;

  int n_checks = 0;
  int n_fail   = 0;

  int first_valid, n_xfer, order_err, last_err, stall_err, beats, timed_out, aborted, busy_rd_valid;
  logic wr_err_at_start, ferr_at_start;
  logic ab_busy, ab_done, ab_civ, ab_cor;
  logic [OW-1:0] rd0, rd1;
  logic rv0, rv1, rv_after;

  always #5 clk = ~clk;

  fft_host_ctrl #(.N_POINTS(N), .ADDR_W(AW), .IN_W(IW), .OUT_W(OW), .BITREV(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .m_addr(m_addr), .m_data(m_data), .m_we(m_we), .start(start),
    .s_addr(s_addr), .s_re(s_re), .s_data(o0_s_data), .s_valid(o0_s_valid), .busy(o0_busy),
    .done(o0_done), .wr_err(o0_wr_err), .frame_err(o0_frame_err),
    .core_in_data(o0_core_in_data), .core_in_valid(o0_core_in_valid), .core_in_last(o0_core_in_last),
    .core_in_ready(core_in_ready), .core_out_data(core_out_data), .core_out_valid(core_out_valid),
    .core_out_last(core_out_last), .core_out_ready(o0_core_out_ready)
  );

  fft_host_ctrl #(.N_POINTS(N), .ADDR_W(AW), .IN_W(IW), .OUT_W(OW), .BITREV(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .m_addr(m_addr), .m_data(m_data), .m_we(m_we), .start(start),
    .s_addr(s_addr), .s_re(s_re), .s_data(o1_s_data), .s_valid(o1_s_valid), .busy(o1_busy),
    .done(o1_done), .wr_err(o1_wr_err), .frame_err(o1_frame_err),
    .core_in_data(o1_core_in_data), .core_in_valid(o1_core_in_valid), .core_in_last(o1_core_in_last),
    .core_in_ready(core_in_ready), .core_out_data(core_out_data), .core_out_valid(core_out_valid),
    .core_out_last(core_out_last), .core_out_ready(o1_core_out_ready)
  );

  task automatic load_ramp();
    for (int k = 0; k < N; k++) begin
      @(negedge clk);
      m_we = 1'b1; m_addr = AW'(k); m_data = IW'(k);
    end
    @(negedge clk);
    m_we = 1'b0;
  endtask

  // Drives one frame through dut0 (dut1 sees identical stimulus) and records what it saw.
  task automatic run_frame(input bit toggle, input int last_beat, input bit inject_we, input int abort_beat);
    int b;
    bit rdy, prev_stall;
    logic [IW-1:0] prev_data;
    first_valid = -1; n_xfer = 0; order_err = 0; last_err = 0; stall_err = 0;
    timed_out = 1; aborted = 0; busy_rd_valid = 0;
    b = 0; prev_stall = 1'b0; prev_data = '0;
    @(negedge clk);
    start = 1'b1;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (o0_done === 1'b1) begin
        timed_out = 0;
        break;
      end
      if (c == 0) begin
        start = 1'b0;
        wr_err_at_start = o0_wr_err;
        ferr_at_start   = o0_frame_err;
      end
      rdy = toggle ? (c % 2 == 0) : 1'b1;
      core_in_ready = rdy;
      if (prev_stall && (o0_core_in_valid !== 1'b1 || o0_core_in_data !== prev_data)) stall_err++;
      if (o0_core_in_valid === 1'b1) begin
        if (first_valid < 0) first_valid = c;
        if (rdy) begin
          if (o0_core_in_data !== IW'(n_xfer)) order_err++;
          if (o0_core_in_last !== (n_xfer == N - 1)) last_err++;
          n_xfer++;
        end
      end
      prev_stall = (o0_core_in_valid === 1'b1) && !rdy;
      prev_data  = o0_core_in_data;
      core_out_valid = 1'b1;
      core_out_data  = 32'hA000_0000 + 32'(b);
      core_out_last  = (b == last_beat);
      if (o0_core_out_ready === 1'b1) begin
        if (b == abort_beat) begin
          rst_n = 1'b0;
          #1;
          ab_busy = o0_busy; ab_done = o0_done; ab_civ = o0_core_in_valid; ab_cor = o0_core_out_ready;
          aborted = 1; timed_out = 0;
          break;
        end
        b++;
      end
      m_we = inject_we && (c == 4); m_addr = 5'd3; m_data = 16'hDEAD;
      s_re = (c == 6); s_addr = '0;
      if (c == 7) busy_rd_valid = int'(o0_s_valid);
    end
    beats = b;
    core_out_valid = 1'b0; core_out_last = 1'b0; core_in_ready = 1'b0; m_we = 1'b0; s_re = 1'b0;
  endtask

  task automatic read_out(input logic [AW-1:0] a);
    @(negedge clk);
    s_re = 1'b1; s_addr = a;
    @(negedge clk);
    s_re = 1'b0;
    rd0 = o0_s_data; rd1 = o1_s_data; rv0 = o0_s_valid; rv1 = o1_s_valid;
    @(negedge clk);
    rv_after = o0_s_valid;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (o0_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", o0_busy); end
    n_checks++; if (o0_done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", o0_done); end
    n_checks++; if (o0_wr_err !== 1'b0) begin n_fail++; $display("FAIL reset_wr_err: got %b want 0", o0_wr_err); end
    n_checks++; if (o0_frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_frame_err: got %b want 0", o0_frame_err); end
    n_checks++; if (o0_core_in_valid !== 1'b0) begin n_fail++; $display("FAIL reset_in_valid: got %b want 0", o0_core_in_valid); end
    n_checks++; if (o0_core_in_last !== 1'b0) begin n_fail++; $display("FAIL reset_in_last: got %b want 0", o0_core_in_last); end
    n_checks++; if (o0_core_out_ready !== 1'b0) begin n_fail++; $display("FAIL reset_out_ready: got %b want 0", o0_core_out_ready); end
    n_checks++; if (o0_s_valid !== 1'b0) begin n_fail++; $display("FAIL reset_s_valid: got %b want 0", o0_s_valid); end
    n_checks++; if (o0_s_data !== 32'h0) begin n_fail++; $display("FAIL reset_s_data: got %h want 0", o0_s_data); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_natural();
    load_ramp();
    run_frame(1'b0, N - 1, 1'b0, -1);
    n_checks++; if (timed_out != 0) begin n_fail++; $display("FAIL nat_timeout: done never rose"); end
    n_checks++; if (first_valid != 2) begin n_fail++; $display("FAIL nat_first_valid: got cycle %0d want 2", first_valid); end
    n_checks++; if (n_xfer != N) begin n_fail++; $display("FAIL nat_xfers: got %0d want %0d", n_xfer, N); end
    n_checks++; if (order_err != 0) begin n_fail++; $display("FAIL nat_order: %0d bad samples want 0", order_err); end
    n_checks++; if (last_err != 0) begin n_fail++; $display("FAIL nat_in_last: %0d bad flags want 0", last_err); end
    n_checks++; if (beats != N) begin n_fail++; $display("FAIL nat_beats: got %0d want %0d", beats, N); end
    n_checks++; if (o0_done !== 1'b1 || o0_busy !== 1'b0) begin n_fail++; $display("FAIL nat_status: done=%b busy=%b want 1/0", o0_done, o0_busy); end
    n_checks++; if (o0_frame_err !== 1'b0) begin n_fail++; $display("FAIL nat_frame_err: got %b want 0", o0_frame_err); end
    n_checks++; if (busy_rd_valid != 0) begin n_fail++; $display("FAIL busy_read: s_valid %0d want 0", busy_rd_valid); end
    read_out(5'd5);
    n_checks++; if (rd0 !== 32'hA000_0005) begin n_fail++; $display("FAIL nat_read5: got %h want a0000005", rd0); end
    n_checks++; if (rv0 !== 1'b1) begin n_fail++; $display("FAIL nat_valid5: got %b want 1", rv0); end
    n_checks++; if (rv_after !== 1'b0) begin n_fail++; $display("FAIL nat_valid_pulse: got %b want 0", rv_after); end
  endtask

  task automatic test_bitrev();
    read_out(5'd16);
    n_checks++; if (rd1 !== 32'hA000_0001) begin n_fail++; $display("FAIL brev_read16: got %h want a0000001", rd1); end
    n_checks++; if (rv1 !== 1'b1) begin n_fail++; $display("FAIL brev_valid16: got %b want 1", rv1); end
    read_out(5'd31);
    n_checks++; if (rd1 !== 32'hA000_001F) begin n_fail++; $display("FAIL brev_read31: got %h want a000001f", rd1); end
    read_out(5'd1);
    n_checks++; if (rd1 !== 32'hA000_0010) begin n_fail++; $display("FAIL brev_read1: got %h want a0000010", rd1); end
    n_checks++; if (rd0 !== 32'hA000_0001) begin n_fail++; $display("FAIL nat_read1: got %h want a0000001", rd0); end
  endtask

  task automatic test_stall();
    run_frame(1'b1, N - 1, 1'b0, -1);
    n_checks++; if (timed_out != 0) begin n_fail++; $display("FAIL stall_timeout: done never rose"); end
    n_checks++; if (n_xfer != N) begin n_fail++; $display("FAIL stall_xfers: got %0d want %0d", n_xfer, N); end
    n_checks++; if (order_err != 0) begin n_fail++; $display("FAIL stall_order: %0d bad samples want 0", order_err); end
    n_checks++; if (last_err != 0) begin n_fail++; $display("FAIL stall_in_last: %0d bad flags want 0", last_err); end
    n_checks++; if (stall_err != 0) begin n_fail++; $display("FAIL stall_stable: %0d changes want 0", stall_err); end
    read_out(5'd31);
    n_checks++; if (rd0 !== 32'hA000_001F) begin n_fail++; $display("FAIL stall_read31: got %h want a000001f", rd0); end
  endtask

  task automatic test_frame_err();
    run_frame(1'b0, 10, 1'b0, -1);
    n_checks++; if (o0_frame_err !== 1'b1) begin n_fail++; $display("FAIL ferr_set: got %b want 1", o0_frame_err); end
    n_checks++; if (beats != N || timed_out != 0) begin n_fail++; $display("FAIL ferr_done_beat: done after %0d beats want %0d", beats, N); end
    run_frame(1'b0, N - 1, 1'b0, -1);
    n_checks++; if (ferr_at_start !== 1'b0) begin n_fail++; $display("FAIL ferr_clear_on_start: got %b want 0", ferr_at_start); end
    n_checks++; if (o0_frame_err !== 1'b0) begin n_fail++; $display("FAIL ferr_clean_frame: got %b want 0", o0_frame_err); end
  endtask

  task automatic test_wr_err();
    run_frame(1'b0, N - 1, 1'b1, -1);
    n_checks++; if (o0_wr_err !== 1'b1) begin n_fail++; $display("FAIL wr_err_set: got %b want 1", o0_wr_err); end
    run_frame(1'b0, N - 1, 1'b0, -1);
    n_checks++; if (wr_err_at_start !== 1'b0) begin n_fail++; $display("FAIL wr_err_clear: got %b want 0", wr_err_at_start); end
    n_checks++; if (order_err != 0 || n_xfer != N) begin n_fail++; $display("FAIL wr_err_data_kept: %0d bad of %0d want 0 of %0d", order_err, n_xfer, N); end
    n_checks++; if (o0_wr_err !== 1'b0) begin n_fail++; $display("FAIL wr_err_stays_clear: got %b want 0", o0_wr_err); end
  endtask

  task automatic test_reset_mid_frame();
    run_frame(1'b0, N - 1, 1'b0, 5);
    n_checks++; if (aborted != 1) begin n_fail++; $display("FAIL abort_reached: got %0d want 1", aborted); end
    n_checks++; if (ab_busy !== 1'b0 || ab_done !== 1'b0) begin n_fail++; $display("FAIL abort_status: busy=%b done=%b want 0/0", ab_busy, ab_done); end
    n_checks++; if (ab_civ !== 1'b0 || ab_cor !== 1'b0) begin n_fail++; $display("FAIL abort_handshake: in_valid=%b out_ready=%b want 0/0", ab_civ, ab_cor); end
    @(negedge clk);
    rst_n = 1'b1;
    run_frame(1'b0, N - 1, 1'b0, -1);
    n_checks++; if (timed_out != 0 || o0_done !== 1'b1) begin n_fail++; $display("FAIL abort_restart_done: done=%b want 1", o0_done); end
    n_checks++; if (n_xfer != N || beats != N) begin n_fail++; $display("FAIL abort_restart_len: xfers=%0d beats=%0d want %0d", n_xfer, beats, N); end
    n_checks++; if (order_err != 0) begin n_fail++; $display("FAIL abort_restart_order: %0d bad samples want 0", order_err); end
  endtask

  initial begin
    test_reset();
    test_natural();
    test_bitrev();
    test_stall();
    test_frame_err();
    test_wr_err();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
